mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the CPU's single memory request/response port between the instruction-fetch stage (read-only) and the memory-access stage (load/store). It sits between the two pipeline stages and the external memory interface. It grants one requester at a time, holds the grant through the whole transaction (request plus read response), and routes response data back to the owner. Memory-access has fixed priority over fetch, bounded by an anti-starvation counter.

## Interface
- STARVE_LIMIT, 8: consecutive memory-access grants allowed while fetch is waiting; the next grant then goes to fetch (≥1).
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- if_addr  in  32  fetch address (word aligned)
- if_rd  in  1  fetch read request; held until if_req_ready
- if_req_ready  out  1  fetch request accepted this cycle
- if_rdata  out  32  fetch response data
- if_rdata_valid  out  1  fetch response valid
- if_rdata_ready  in  1  fetch can accept response
- ma_addr  in  32  load/store address (word aligned)
- ma_rd / ma_wr  in  1 each  load / store request; held until ma_req_ready
- ma_wdata  in  32  store data
- ma_wstrb  in  4  store byte strobes
- ma_req_ready  out  1  load/store request accepted this cycle
- ma_rdata  out  32  load response data
- ma_rdata_valid  out  1  load response valid
- ma_rdata_ready  in  1  MA can accept response
- mem_addr  out  32  memory address
- mem_rd / mem_wr  out  1 each  memory read / write request
- mem_wdata, mem_wstrb  out  32, 4  memory write data and strobes
- mem_req_ready  in  1  memory accepted request
- mem_rdata  in  32  memory read data
- mem_rdata_valid  in  1  memory read data valid
- mem_rdata_ready  out  1  arbiter accepts read data

## Operation
- States: S_IDLE, S_REQ, S_RESP. A grant register (GNT: 0 = IF, 1 = MA) is written only in S_IDLE.
- S_IDLE:
  - Requests present: pick winner, load GNT, go to S_REQ.
  - MA wins if (ma_rd|ma_wr) and not starving.
  - Starving means if_rd=1 and wait counter == STARVE_LIMIT; IF then wins.
  - Otherwise IF wins if if_rd=1. No request: stay.
- S_REQ:
  - mem_addr/mem_rd/mem_wr/mem_wdata/mem_wstrb driven from GNT owner; ma_wr overrides ma_rd if both are high; IF never writes.
  - On mem_req_ready: pulse owner's *_req_ready the same cycle. Write → S_IDLE; read → S_RESP.
- S_RESP:
  - mem_rdata_ready = owner's rdata_ready.
  - Owner's rdata_valid = mem_rdata_valid; owner's rdata = mem_rdata.
  - On valid&ready → S_IDLE.
- Outside S_REQ: all mem_* request outputs are 0. Outside S_RESP: both *_rdata_valid are 0. The non-owner's ready/valid outputs are always 0.
- Wait counter, width clog2(STARVE_LIMIT+1), updated at S_IDLE decisions only:
  - MA granted while if_rd=1: +1, saturating.
  - IF granted, or if_rd=0: clear.
- Drain: a register captures ~rst_n. In the first cycle after reset release, mem_rdata_ready=1 and mem_rdata_valid is forwarded to neither requester. This discards any response left over from before reset.

## Timing
- Reset (rst_n=0 at edge): state=S_IDLE, GNT=0, counter=0.
- Reset output values: all mem_* request outputs 0, both *_req_ready 0, both *_rdata_valid 0. mem_rdata_ready=1 during the drain cycle, else 0.
- Arbitration latency: request seen in S_IDLE at edge N → mem_rd/mem_wr high in cycle N+1.
- Minimum occupancy:
  - Write: 2 cycles (IDLE, REQ), with mem_req_ready=1 immediately.
  - Read: 3 cycles (IDLE, REQ, RESP), with zero-wait memory.
- Requesters must hold request signals stable until *_req_ready. Dropping a request early is illegal and is not checked.
- Only one transaction is outstanding at a time. A new grant is issued only after returning to S_IDLE, so back-to-back grants are spaced by the S_IDLE cycle.
- Reset mid-transaction: abandon at once, return to S_IDLE; a late response is absorbed by the drain cycle.
- Simultaneous IF and MA requests in S_IDLE: MA wins unless IF is starving.

## Test plan
- Reset: hold rst_n=0 for 3 cycles, release → cycle 1 after release: mem_rdata_ready=1, if/ma_rdata_valid=0 even if mem_rdata_valid=1; cycle 2: mem_rdata_ready=0, all request outputs 0.
- IF read alone: if_rd=1, if_addr=0x0000_0100, memory ready immediately, returns 0x0000_0013 two cycles later → mem_addr=0x100 in S_REQ, if_req_ready one pulse, if_rdata=0x13 with if_rdata_valid; ma_* outputs stay 0.
- Contention: if_rd and ma_wr (addr 0x200, data 0xDEADBEEF, strb 4'b0011) raised the same cycle → MA store issued first with exact data/strb; IF read issued only after return to S_IDLE.
- Response backpressure: MA load, mem_rdata_valid=1 while ma_rdata_ready=0 for 3 cycles → stays in S_RESP, mem_rdata_ready=0, no IF request issued; completes on the cycle ma_rdata_ready=1.
- Starvation with STARVE_LIMIT=2: if_rd held high, ma_rd re-asserted after every completion → grant order MA, MA, IF, MA, MA, IF.
- Reset mid-read: rst_n=0 while in S_RESP with memory still pending, then memory returns valid in the first cycle after release → data dropped, no *_rdata_valid pulse, next if_rd served normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory request/response port between the
// instruction-fetch stage (read-only) and the memory-access stage (load/store).
// One transaction is in flight at a time; the grant is held from request
// through read response. Memory-access has fixed priority, bounded by a
// wait counter that forces a fetch grant after STARVE_LIMIT consecutive
// memory-access grants while fetch was waiting.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    // instruction fetch
    input  logic [31:0] if_addr,
    input  logic        if_rd,
    output logic        if_req_ready,
    output logic [31:0] if_rdata,
    output logic        if_rdata_valid,
    input  logic        if_rdata_ready,
    // memory access (load/store)
    input  logic [31:0] ma_addr,
    input  logic        ma_rd,
    input  logic        ma_wr,
    input  logic [31:0] ma_wdata,
    input  logic [3:0]  ma_wstrb,
    output logic        ma_req_ready,
    output logic [31:0] ma_rdata,
    output logic        ma_rdata_valid,
    input  logic        ma_rdata_ready,
    // external memory
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_req_ready,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rdata_valid,
    output logic        mem_rdata_ready
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_LIMIT);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          gnt_q, gnt_d;          // 0 = fetch owns the port, 1 = memory-access
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic          drain_q;               // high for the cycle after reset is released

    logic in_req, in_resp;
    logic ma_any, if_starving, ma_wins;
    logic owner_is_write, owner_rready;

    assign in_req         = (state_q == S_REQ);
    assign in_resp        = (state_q == S_RESP);
    assign ma_any         = ma_rd | ma_wr;
    assign if_starving    = if_rd & (wait_cnt_q == CNT_MAX);
    assign ma_wins        = ma_any & ~if_starving;
    // A store wins over a load if both are raised; fetch never writes.
    assign owner_is_write = gnt_q & ma_wr;
    assign owner_rready   = gnt_q ? ma_rdata_ready : if_rdata_ready;

    // Next-state, grant selection and starvation counting
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (ma_wins) begin
                    gnt_d   = 1'b1;
                    state_d = S_REQ;
                end else if (if_rd) begin
                    gnt_d   = 1'b0;
                    state_d = S_REQ;
                end
                // Count memory-access grants that left fetch waiting; anything else clears.
                if (ma_wins && if_rd) begin
                    wait_cnt_d = (wait_cnt_q == CNT_MAX) ? wait_cnt_q : wait_cnt_q + CW'(1);
                end else begin
                    wait_cnt_d = '0;
                end
            end
            S_REQ: begin
                if (mem_req_ready) begin
                    state_d = owner_is_write ? S_IDLE : S_RESP;
                end
            end
            S_RESP: begin
                if (mem_rdata_valid && owner_rready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Route the owner's request to memory and the memory response back to the owner
    always_comb begin
        mem_addr        = '0;
        mem_rd          = 1'b0;
        mem_wr          = 1'b0;
        mem_wdata       = '0;
        mem_wstrb       = '0;
        if_req_ready    = 1'b0;
        ma_req_ready    = 1'b0;
        if_rdata        = '0;
        if_rdata_valid  = 1'b0;
        ma_rdata        = '0;
        ma_rdata_valid  = 1'b0;
        mem_rdata_ready = drain_q;
        if (in_req) begin
            if (gnt_q) begin
                mem_addr     = ma_addr;
                mem_wr       = ma_wr;
                mem_rd       = ma_rd & ~ma_wr;
                mem_wdata    = ma_wr ? ma_wdata : '0;
                mem_wstrb    = ma_wr ? ma_wstrb : '0;
                ma_req_ready = mem_req_ready;
            end else begin
                mem_addr     = if_addr;
                mem_rd       = if_rd;
                if_req_ready = mem_req_ready;
            end
        end
        if (in_resp) begin
            mem_rdata_ready = drain_q | owner_rready;
            if (gnt_q) begin
                ma_rdata       = mem_rdata;
                ma_rdata_valid = mem_rdata_valid;
            end else begin
                if_rdata       = mem_rdata;
                if_rdata_valid = mem_rdata_valid;
            end
        end
    end

    // State, grant, counter and post-reset drain registers
    always_ff @(posedge clk) begin
        drain_q <= ~rst_n;
        if (!rst_n) begin
            state_q    <= S_IDLE;
            gnt_q      <= 1'b0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios plus a randomized phase,
// checked every cycle against a transaction-level model of the port owner.
module tb_mem_port_arbiter;

    localparam int LIM = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_addr;
    logic        if_rd;
    logic        if_req_ready;
    logic [31:0] if_rdata;
    logic        if_rdata_valid;
    logic        if_rdata_ready;
    logic [31:0] ma_addr;
    logic        ma_rd;
    logic        ma_wr;
    logic [31:0] ma_wdata;
    logic [3:0]  ma_wstrb;
    logic        ma_req_ready;
    logic [31:0] ma_rdata;
    logic        ma_rdata_valid;
    logic        ma_rdata_ready;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_req_ready;
    logic [31:0] mem_rdata;
    logic        mem_rdata_valid;
    logic        mem_rdata_ready;

    mem_port_arbiter #(.STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_addr(if_addr), .if_rd(if_rd), .if_req_ready(if_req_ready),
        .if_rdata(if_rdata), .if_rdata_valid(if_rdata_valid), .if_rdata_ready(if_rdata_ready),
        .ma_addr(ma_addr), .ma_rd(ma_rd), .ma_wr(ma_wr), .ma_wdata(ma_wdata), .ma_wstrb(ma_wstrb),
        .ma_req_ready(ma_req_ready), .ma_rdata(ma_rdata), .ma_rdata_valid(ma_rdata_valid),
        .ma_rdata_ready(ma_rdata_ready),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_req_ready(mem_req_ready), .mem_rdata(mem_rdata),
        .mem_rdata_valid(mem_rdata_valid), .mem_rdata_ready(mem_rdata_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- reference model: who owns the port and what it awaits
    bit m_busy = 0, m_owner_ma = 0, m_await = 0, m_drain = 0;
    int m_streak = 0;   // MA grants in a row while fetch was waiting

    always @(posedge clk) begin
        m_drain <= !rst_n;
        if (!rst_n) begin
            m_busy <= 0; m_await <= 0; m_streak <= 0;
        end else if (!m_busy) begin
            if ((ma_rd || ma_wr) && !(if_rd && m_streak == LIM)) begin
                m_busy <= 1; m_owner_ma <= 1;
                m_streak <= if_rd ? ((m_streak < LIM) ? m_streak + 1 : LIM) : 0;
            end else begin
                if (if_rd) begin m_busy <= 1; m_owner_ma <= 0; end
                m_streak <= 0;
            end
        end else if (!m_await) begin
            if (mem_req_ready) begin
                if (m_owner_ma && ma_wr) m_busy <= 0;
                else m_await <= 1;
            end
        end else if (mem_rdata_valid && (m_owner_ma ? ma_rdata_ready : if_rdata_ready)) begin
            m_busy <= 0; m_await <= 0;
        end
    end

    // ---------------- per-cycle compare and handshake recording (negedge)
    bit check_en = 0;
    bit h_if_acc, h_ma_acc, h_mem_acc, h_mem_wr, h_mem_rresp;
    logic [31:0] h_addr, h_wdata;
    logic [3:0]  h_wstrb;
    bit dut_grants[$];
    int valid_pulses = 0;

    always @(negedge clk) begin
        logic e_rq, e_rs, e_rd, e_wr, e_ifr, e_mar, e_ifv, e_mav, e_rr;
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_wstrb;
        h_if_acc    = if_rd && if_req_ready;
        h_ma_acc    = (ma_rd || ma_wr) && ma_req_ready;
        h_mem_acc   = (mem_rd || mem_wr) && mem_req_ready;
        h_mem_wr    = mem_wr;
        h_addr      = mem_addr;
        h_wdata     = mem_wdata;
        h_wstrb     = mem_wstrb;
        h_mem_rresp = mem_rdata_valid && mem_rdata_ready;
        if (if_req_ready) dut_grants.push_back(1'b0);
        if (ma_req_ready) dut_grants.push_back(1'b1);
        if (if_rdata_valid || ma_rdata_valid) valid_pulses++;
        if (check_en) begin
            e_rq    = m_busy && !m_await;
            e_rs    = m_busy && m_await;
            e_wr    = e_rq && m_owner_ma && ma_wr;
            e_rd    = e_rq && (m_owner_ma ? (ma_rd && !ma_wr) : if_rd);
            e_addr  = e_rq ? (m_owner_ma ? ma_addr : if_addr) : 32'h0;
            e_wdata = e_wr ? ma_wdata : 32'h0;
            e_wstrb = e_wr ? ma_wstrb : 4'h0;
            e_ifr   = e_rq && !m_owner_ma && mem_req_ready;
            e_mar   = e_rq && m_owner_ma && mem_req_ready;
            e_ifv   = e_rs && !m_owner_ma && mem_rdata_valid;
            e_mav   = e_rs && m_owner_ma && mem_rdata_valid;
            e_rr    = m_drain || (e_rs && (m_owner_ma ? ma_rdata_ready : if_rdata_ready));
            chk("cycle",
                128'({mem_rd, mem_wr, if_req_ready, ma_req_ready, if_rdata_valid, ma_rdata_valid,
                      mem_rdata_ready, mem_addr, mem_wdata, mem_wstrb}),
                128'({e_rd, e_wr, e_ifr, e_mar, e_ifv, e_mav, e_rr, e_addr, e_wdata, e_wstrb}));
            if (e_ifv) chk("if_rdata_route", 128'(if_rdata), 128'(mem_rdata));
            if (e_mav) chk("ma_rdata_route", 128'(ma_rdata), 128'(mem_rdata));
        end
    end

    // ---------------- memory and requester agents (advanced once per cycle)
    logic [31:0] mem_arr [logic [31:0]];
    bit mem_auto = 0, mem_rand = 0, pend = 0;
    logic [31:0] pend_addr;
    int pend_cnt;
    bit req_rand = 0, if_again = 0, ma_again = 0;

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem_arr.exists(a)) return mem_arr[a];
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic mem_tick();
        logic [31:0] v;
        if (h_mem_rresp) mem_rdata_valid = 1'b0;
        if (h_mem_acc) begin
            if (h_mem_wr) begin
                v = mem_read(h_addr);
                for (int b = 0; b < 4; b++) if (h_wstrb[b]) v[8*b +: 8] = h_wdata[8*b +: 8];
                mem_arr[h_addr] = v;
            end else begin
                pend = 1; pend_addr = h_addr;
                pend_cnt = mem_rand ? int'($urandom_range(0, 3)) : 0;
            end
        end
        if (pend) begin
            if (pend_cnt == 0) begin
                mem_rdata_valid = 1'b1; mem_rdata = mem_read(pend_addr); pend = 0;
            end else pend_cnt--;
        end
        mem_req_ready = mem_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    endtask

    task automatic req_tick();
        int op;
        if (h_if_acc) if_rd = if_again;
        if (h_ma_acc) begin ma_rd = ma_again; ma_wr = 1'b0; end
        if (req_rand) begin
            if (!if_rd && $urandom_range(0, 2) == 0) begin
                if_rd = 1'b1; if_addr = 32'($urandom_range(0, 63)) << 2;
            end
            if (!ma_rd && !ma_wr && $urandom_range(0, 2) == 0) begin
                op = int'($urandom_range(0, 3));
                ma_rd    = (op != 2);
                ma_wr    = (op >= 2);
                ma_addr  = 32'($urandom_range(0, 63)) << 2;
                ma_wdata = $urandom();
                ma_wstrb = 4'($urandom_range(1, 15));
            end
            if_rdata_ready = ($urandom_range(0, 3) != 0);
            ma_rdata_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (mem_auto) mem_tick();
        req_tick();
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // ---------------- stimulus
    initial begin
        logic [5:0]  order;
        logic [31:0] rd_data;
        bit          got;
        rst_n = 1'b0;
        if_addr = '0; if_rd = 0; if_rdata_ready = 1;
        ma_addr = '0; ma_rd = 0; ma_wr = 0; ma_wdata = '0; ma_wstrb = '0; ma_rdata_ready = 1;
        mem_req_ready = 1; mem_rdata = 32'hBAD0_0BAD; mem_rdata_valid = 1;
        mem_arr[32'h100] = 32'h0000_0013;
        mem_arr[32'h200] = 32'h1122_3344;

        // Reset with a stale response present; it must be drained, not forwarded.
        step();
        check_en = 1;
        step(); step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("drain", 128'({mem_rdata_ready, if_rdata_valid, ma_rdata_valid}), 128'(3'b100));
        step();
        mem_rdata_valid = 0;
        @(negedge clk);
        chk("post_drain", 128'({mem_rdata_ready, mem_rd, mem_wr, if_req_ready, ma_req_ready}), 128'(5'b0));
        mem_auto = 1;
        step();

        // Fetch read alone.
        valid_pulses = 0; dut_grants.delete();
        if_rd = 1; if_addr = 32'h100;
        @(negedge clk);
        chk("if_lat0", 128'({mem_rd, mem_wr}), 128'(2'b00));
        step(); @(negedge clk);
        chk("if_req", 128'({mem_rd, mem_wr, if_req_ready, ma_req_ready, mem_addr}),
            128'({1'b1, 1'b0, 1'b1, 1'b0, 32'h100}));
        step(); @(negedge clk);
        chk("if_resp", 128'({if_rdata_valid, ma_rdata_valid, if_rdata}), 128'({1'b1, 1'b0, 32'h13}));
        step();
        chk("if_grants", 128'({dut_grants.size(), dut_grants[0]}), 128'({32'd1, 1'b0}));

        // Contention: store wins, fetch follows after the idle cycle.
        if_rd = 1; if_addr = 32'h300;
        ma_wr = 1; ma_addr = 32'h200; ma_wdata = 32'hDEADBEEF; ma_wstrb = 4'b0011;
        @(negedge clk);
        step(); @(negedge clk);
        chk("cont_ma_first",
            128'({mem_wr, mem_rd, ma_req_ready, if_req_ready, mem_addr, mem_wdata, mem_wstrb}),
            128'({1'b1, 1'b0, 1'b1, 1'b0, 32'h200, 32'hDEADBEEF, 4'b0011}));
        step(); @(negedge clk);
        chk("cont_gap", 128'({mem_rd, mem_wr, if_req_ready}), 128'(3'b000));
        step(); @(negedge clk);
        chk("cont_if_next", 128'({mem_rd, mem_wr, if_req_ready, mem_addr}),
            128'({1'b1, 1'b0, 1'b1, 32'h300}));
        settle(4);

        // Load response backpressure.
        ma_rd = 1; ma_addr = 32'h200; ma_rdata_ready = 0;
        if_rd = 1; if_addr = 32'h104;
        step(); step();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_hold", 128'({ma_rdata_valid, mem_rdata_ready, mem_rd, mem_wr, if_req_ready}),
                128'(5'b10000));
            step();
        end
        ma_rdata_ready = 1;
        @(negedge clk);
        chk("bp_done", 128'({ma_rdata_valid, mem_rdata_ready, ma_rdata}),
            128'({1'b1, 1'b1, 32'h1122BEEF}));
        settle(6);

        // Starvation bound: MA, MA, IF repeating.
        dut_grants.delete();
        if_again = 1; ma_again = 1;
        if_rd = 1; if_addr = 32'h108; ma_rd = 1; ma_addr = 32'h20C;
        for (int i = 0; i < 100 && dut_grants.size() < 6; i++) step();
        if_again = 0; ma_again = 0;
        if (dut_grants.size() < 6) begin
            chk("starve_timeout", 128'(dut_grants.size()), 128'(6));
        end else begin
            for (int i = 0; i < 6; i++) order[5-i] = dut_grants[i];
            chk("starve_order", 128'(order), 128'(6'b110110));
        end
        settle(14);

        // Reset in the middle of a read; the late response is absorbed.
        mem_auto = 0; mem_req_ready = 1; mem_rdata_valid = 0;
        if_rd = 1; if_addr = 32'h100;
        step(); step();
        @(negedge clk);
        chk("rmr_in_resp", 128'({if_rdata_valid, mem_rdata_ready}), 128'(2'b01));
        step();
        rst_n = 0; mem_req_ready = 0;
        step();
        rst_n = 1; mem_rdata_valid = 1; mem_rdata = 32'hDEAD0001;
        valid_pulses = 0;
        @(negedge clk);
        chk("rmr_drain", 128'({mem_rdata_ready, if_rdata_valid, ma_rdata_valid}), 128'(3'b100));
        step();
        mem_rdata_valid = 0; mem_req_ready = 1; pend = 0; mem_auto = 1;
        step();
        chk("rmr_no_valid", 128'(valid_pulses), 128'(0));
        if_rd = 1; if_addr = 32'h100;
        got = 0; rd_data = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (if_rdata_valid) begin got = 1; rd_data = if_rdata; break; end
            step();
        end
        chk("rmr_next_read", 128'({got, rd_data}), 128'({1'b1, 32'h13}));
        settle(3);

        // Randomized traffic against the model.
        req_rand = 1; mem_rand = 1;
        settle(3000);
        req_rand = 0; mem_rand = 0; if_rdata_ready = 1; ma_rdata_ready = 1;
        settle(40);
        chk("final_quiet", 128'({if_rd, ma_rd, ma_wr, mem_rd, mem_wr}), 128'(5'b0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
